i2c_req_arbiter: RTL and testbench
==================================

Name: i2c_req_arbiter

Overview:
Round-robin scheduler that shares one I2C EEPROM master between NUM_REQ requesters. It latches the winning request's mode, address and write data, then pulses the master's new-data input. It waits for the master's done, then returns read data and a one-cycle response strobe to the winner. It sits between client logic and the I2C master, in the master's clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NEWD_CYCLES, 24, clk cycles m_newd is held high; must exceed one master bit-clock period (22 clk)
TIMEOUT_CYCLES, 4096, clk cycles in WAIT_DONE before abort (only with I2C_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level
req_wr  input  NUM_REQ  per-requester mode, 1=write 0=read
req_addr  input  7*NUM_REQ  per-requester 7-bit device address, requester k at bits [7k+6:7k]
req_wdata  input  8*NUM_REQ  per-requester write byte, requester k at bits [8k+7:8k]
gnt  output  NUM_REQ  one-hot, high from ISSUE through RESP for the winner
rsp_valid  output  NUM_REQ  one-cycle completion strobe to the winner
rsp_rdata  output  8  read byte, valid with rsp_valid
rsp_err  output  1  1 = transaction aborted by timeout, valid with rsp_valid
busy  output  1  high in any state except IDLE
m_newd  output  1  to master newd
m_wr  output  1  to master wr
m_addr  output  7  to master addr
m_wdata  output  8  to master wdata
m_rdata  input  8  from master rdata
m_done  input  1  from master done

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, all outputs 0, timeout counter 0, m_done edge register 0.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE: if any req bit is set, pick the first set bit searching from rr_ptr upward with wrap. Latch its wr/addr/wdata into m_wr/m_addr/m_wdata, set gnt one-hot, go to ISSUE the next cycle. If no req is set, stay in IDLE.
- ISSUE: m_newd=1 for exactly NEWD_CYCLES cycles, then m_newd=0 and go to WAIT_DONE. m_* fields stay stable from ISSUE until leaving RESP.
- WAIT_DONE: detect the rising edge of m_done using a registered copy. Waiting for the edge, not the level, rejects a stale done held from a previous transaction. On the edge, capture m_rdata into rsp_rdata, set rsp_err=0, go to RESP.
- RESP: one cycle. rsp_valid[winner]=1. rr_ptr <= winner+1, wrapping to 0 at NUM_REQ. gnt cleared on exit. Next state is IDLE.
- Latency: req to m_newd rise = 2 cycles. m_done edge to rsp_valid = 2 cycles. Minimum gap between consecutive grants = 1 IDLE cycle.
- Requester rules:
  - Hold req and its fields stable until the rsp_valid strobe.
  - Dropping req before grant withdraws the request.
  - Dropping req after grant is ignored; the transaction still completes and rsp_valid still fires.
  - A requester may re-assert req in the cycle after its rsp_valid.
- Fairness: after a requester is served it has lowest priority. Simultaneous requests are served in rotating order.
- rsp_rdata holds its last value outside RESP. It is updated only in WAIT_DONE to RESP, including on writes, when it captures whatever m_rdata shows.
- Reset mid-transaction: the FSM aborts to IDLE and no rsp_valid is issued. The master is reset by the same system reset.

Optional Feature:
I2C_ARB_TIMEOUT_EN:
- Defined: a counter runs in WAIT_DONE and is cleared on entry. When it reaches TIMEOUT_CYCLES-1 with no m_done edge, go to RESP with rsp_err=1 and rsp_rdata=0.
- Not defined: no counter. WAIT_DONE waits indefinitely; rsp_err is tied 0.

Decomposition:
- Package i2c_arb_pkg: FSM state encoding (2-bit), I2C address width 7, data width 8, default NEWD_CYCLES and TIMEOUT_CYCLES.
- Sub-module rr_pick: combinational round-robin one-hot selector (req, rr_ptr -> grant one-hot + index), reusable by other arbiters.

Test Plan:
- Single write: req[1]=1, wr=1, addr=0x50, wdata=0xA5 -> 2 cycles later m_newd high for 24 cycles with m_addr=0x50 and m_wdata=0xA5. The model asserts m_done; 2 cycles later rsp_valid=4'b0010 and rsp_err=0.
- Single read: req[2], wr=0, model returns m_rdata=0x3C with m_done -> rsp_rdata=0x3C with rsp_valid[2] for 1 cycle.
- Contention: req=4'b1111 held continuously, rr_ptr=0 -> grants in order 0,1,2,3,0, each followed by exactly one rsp_valid.
- Stale done: m_done held high across the end of one transaction into the next grant -> no early completion; rsp_valid only after a fresh m_done edge.
- Reset mid-op: rst=0 during WAIT_DONE -> all outputs 0 immediately with no rsp_valid. After release, a pending req[3] is granted with rr_ptr=0.
- Timeout (I2C_ARB_TIMEOUT_EN): no m_done -> after 4096 cycles in WAIT_DONE, rsp_valid with rsp_err=1 and rsp_rdata=0x00. The next requester is then granted.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared constants for the I2C requester arbiter: field widths, default timing, FSM encoding.
package i2c_arb_pkg;

    localparam int unsigned ADDR_W             = 7;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned NEWD_CYCLES_DEF    = 24;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_RESP      = 2'd3;

    // (base + off) modulo n, valid for base < n and off < n
    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i, with wrap.
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [IDX_W-1:0]   idx_c_o,
    output logic               any_c_o
);

    logic [IDX_W-1:0] cand_c [NUM_REQ];

    // Candidate index for each search position, starting at the pointer
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
        assign cand_c[g] = IDX_W'(wrap_idx(32'(ptr_i), unsigned'(g), NUM_REQ));
    end

    // Take the first active request in search order
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_c_o && req_i[cand_c[i]]) begin
                any_c_o             = 1'b1;
                idx_c_o             = cand_c[i];
                gnt_c_o[cand_c[i]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM master between NUM_REQ requesters.
// Optional abort-on-timeout in WAIT_DONE is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned NEWD_CYCLES    = NEWD_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      m_newd,
    output logic                      m_wr,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_done
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_MAX = (NEWD_CYCLES > TIMEOUT_CYCLES) ? NEWD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               busy_q, busy_d;
    logic               m_newd_q, m_newd_d;
    logic               m_wr_q, m_wr_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [DATA_W-1:0]  m_wdata_q, m_wdata_d;
`ifdef I2C_ARB_TIMEOUT_EN
    logic               rsp_err_q, rsp_err_d;
`endif

    logic [NUM_REQ-1:0] pick_oh_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               pick_any_c;
    logic               done_rise_c;
    logic [ADDR_W-1:0]  addr_a [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];

    // Split the flat per-requester buses into indexable arrays
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .gnt_c_o (pick_oh_c),
        .idx_c_o (pick_idx_c),
        .any_c_o (pick_any_c)
    );

    // Edge, not level, so a done held over from the last transaction is ignored
    assign done_rise_c = m_done & ~done_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        m_newd_d    = 1'b0;
        m_wr_d      = m_wr_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any_c) begin
                    win_d     = pick_idx_c;
                    gnt_d     = pick_oh_c;
                    m_wr_d    = req_wr[pick_idx_c];
                    m_addr_d  = addr_a[pick_idx_c];
                    m_wdata_d = wdata_a[pick_idx_c];
                    cnt_d     = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == CNT_W'(NEWD_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else begin
                    m_newd_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (done_rise_c) begin
                    rsp_rdata_d = m_rdata;
`ifdef I2C_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = ST_RESP;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                rsp_valid_d = gnt_q;
                rr_ptr_d    = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                gnt_d       = '0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            m_newd_q    <= 1'b0;
            m_wr_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            done_q      <= m_done;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            m_newd_q    <= m_newd_d;
            m_wr_q      <= m_wr_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // Abort flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rsp_err_q <= 1'b0;
        else      rsp_err_q <= rsp_err_d;
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign m_newd    = m_newd_q;
    assign m_wr      = m_wr_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter; the bench drives m_done/m_rdata as the I2C master.
// Timeout scenario is included when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_req_arbiter;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   req_wr;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_rdata;
    logic           rsp_err;
    logic           busy;
    logic           m_newd;
    logic           m_wr;
    logic [6:0]     m_addr;
    logic [7:0]     m_wdata;
    logic [7:0]     m_rdata;
    logic           m_done;

    int n_cmp = 0;
    int n_err = 0;

    i2c_req_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .m_newd    (m_newd),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_done    (m_done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        m_rdata = '0; m_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt, rsp_valid, rsp_rdata, rsp_err, busy, m_newd, m_wr, m_addr, m_wdata} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {gnt, rsp_valid, rsp_rdata, rsp_err, busy, m_newd, m_wr, m_addr, m_wdata});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0) begin
            n_err++; $display("FAIL reset_idle: busy=%b gnt=%b want 0 0000", busy, gnt);
        end
    endtask

    task automatic test_single_write();
        int hi;
        req_wr[1] = 1'b1; req_addr[7 +: 7] = 7'h50; req_wdata[8 +: 8] = 8'hA5; m_rdata = 8'h11;
        req[1] = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 4'b0010 || m_newd !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL write_grant: gnt=%b newd=%b busy=%b want 0010 0 1", gnt, m_newd, busy);
        end
        n_cmp++;
        if ({m_wr, m_addr, m_wdata} !== {1'b1, 7'h50, 8'hA5}) begin
            n_err++; $display("FAIL write_fields: wr=%b addr=%h wdata=%h want 1 50 a5", m_wr, m_addr, m_wdata);
        end
        req[1] = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (m_newd !== 1'b1) begin
            n_err++; $display("FAIL newd_latency: newd=%b want 1", m_newd);
        end
        hi = 1;
        repeat (29) begin
            @(posedge clk); #1;
            if (m_newd === 1'b1) hi++;
        end
        n_cmp++;
        if (hi != 24 || m_addr !== 7'h50 || m_wdata !== 8'hA5) begin
            n_err++; $display("FAIL newd_width: high=%0d addr=%h want 24 50", hi, m_addr);
        end
        m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
        n_cmp++;
        if (rsp_valid !== 4'b0 || gnt !== 4'b0010) begin
            n_err++; $display("FAIL write_resp_early: rsp_valid=%b gnt=%b want 0000 0010", rsp_valid, gnt);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_rdata !== 8'h11 || gnt !== 4'b0) begin
            n_err++; $display("FAIL write_resp: rsp_valid=%b err=%b rdata=%h gnt=%b want 0010 0 11 0000",
                              rsp_valid, rsp_err, rsp_rdata, gnt);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL write_resp_width: rsp_valid=%b busy=%b want 0000 0", rsp_valid, busy);
        end
    endtask

    task automatic test_single_read();
        req_wr[2] = 1'b0; req_addr[14 +: 7] = 7'h51; m_rdata = 8'h00;
        req[2] = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 4'b0100 || m_wr !== 1'b0 || m_addr !== 7'h51) begin
            n_err++; $display("FAIL read_grant: gnt=%b wr=%b addr=%h want 0100 0 51", gnt, m_wr, m_addr);
        end
        req[2] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        m_rdata = 8'h3C; m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h3C) begin
            n_err++; $display("FAIL read_resp: rsp_valid=%b rdata=%h want 0100 3c", rsp_valid, rsp_rdata);
        end
        m_rdata = 8'hEE;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 4'b0 || rsp_rdata !== 8'h3C) begin
            n_err++; $display("FAIL read_hold: rsp_valid=%b rdata=%h want 0000 3c", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_contention();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_oh;
        int wait_n, hits, bad;
        for (int k = 0; k < 4; k++) begin
            req_addr[k*7 +: 7]  = 7'(32'h20 + k);
            req_wdata[k*8 +: 8] = 8'(32'hC0 + k);
            req_wr[k]           = 1'b1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_oh = 4'(1 << order[t]);
            wait_n = 0;
            while (gnt === 4'b0 && wait_n < 40) begin
                @(posedge clk); #1;
                wait_n++;
            end
            n_cmp++;
            if (gnt !== exp_oh || m_addr !== 7'(32'h20 + order[t])) begin
                n_err++; $display("FAIL contention_grant%0d: gnt=%b addr=%h want %b %h",
                                  t, gnt, m_addr, exp_oh, 7'(32'h20 + order[t]));
            end
            if (t == 4) req = '0;
            repeat (30) @(posedge clk);
            #1;
            m_done = 1'b1;
            @(posedge clk); #1;
            m_done = 1'b0;
            hits = 0; bad = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (rsp_valid !== 4'b0) begin
                    hits++;
                    if (rsp_valid !== exp_oh) bad++;
                end
            end
            n_cmp++;
            if (hits != 1 || bad != 0) begin
                n_err++; $display("FAIL contention_resp%0d: strobes=%0d wrong=%0d want 1 0", t, hits, bad);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL contention_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_stale_done();
        int wait_n, hits;
        req_wr[0] = 1'b1; req_addr[0 +: 7] = 7'h30; req_wdata[0 +: 8] = 8'h5A;
        req[0] = 1'b1;
        wait_n = 0;
        while (gnt === 4'b0 && wait_n < 40) begin
            @(posedge clk); #1;
            wait_n++;
        end
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++; $display("FAIL stale_first_grant: gnt=%b want 0001", gnt);
        end
        req[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        m_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== 4'b0001) begin
            n_err++; $display("FAIL stale_first_resp: rsp_valid=%b want 0001", rsp_valid);
        end
        req_wr[3] = 1'b0; req_addr[21 +: 7] = 7'h33;
        req[3] = 1'b1;
        wait_n = 0;
        while (gnt === 4'b0 && wait_n < 40) begin
            @(posedge clk); #1;
            wait_n++;
        end
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_err++; $display("FAIL stale_second_grant: gnt=%b want 1000", gnt);
        end
        req[3] = 1'b0;
        hits = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid !== 4'b0) hits++;
        end
        n_cmp++;
        if (hits != 0 || busy !== 1'b1) begin
            n_err++; $display("FAIL stale_no_early: strobes=%0d busy=%b want 0 1", hits, busy);
        end
        m_done = 1'b0;
        @(posedge clk); #1;
        m_rdata = 8'h9E; m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 4'b1000 || rsp_rdata !== 8'h9E) begin
            n_err++; $display("FAIL stale_fresh_resp: rsp_valid=%b rdata=%h want 1000 9e", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int wait_n, hits;
        req_wr[1] = 1'b1; req_addr[7 +: 7] = 7'h41;
        req[1] = 1'b1;
        wait_n = 0;
        while (gnt === 4'b0 && wait_n < 40) begin
            @(posedge clk); #1;
            wait_n++;
        end
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_err++; $display("FAIL midreset_grant: gnt=%b want 0010", gnt);
        end
        req[1] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        req_wr[3] = 1'b0; req_addr[21 +: 7] = 7'h43;
        req[3] = 1'b1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, rsp_valid, rsp_rdata, rsp_err, busy, m_newd, m_wr, m_addr, m_wdata} !== 36'h0) begin
            n_err++; $display("FAIL midreset_async: got %h want 0",
                              {gnt, rsp_valid, rsp_rdata, rsp_err, busy, m_newd, m_wr, m_addr, m_wdata});
        end
        hits = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid !== 4'b0) hits++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        if (rsp_valid !== 4'b0) hits++;
        n_cmp++;
        if (hits != 0 || gnt !== 4'b1000 || m_addr !== 7'h43) begin
            n_err++; $display("FAIL midreset_regrant: strobes=%0d gnt=%b addr=%h want 0 1000 43", hits, gnt, m_addr);
        end
        req[3] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        m_rdata = 8'h77; m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 4'b1000 || rsp_rdata !== 8'h77) begin
            n_err++; $display("FAIL midreset_resp: rsp_valid=%b rdata=%h want 1000 77", rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int wait_n;
        req_wr[2] = 1'b0; req_addr[14 +: 7] = 7'h52;
        req_wr[3] = 1'b0; req_addr[21 +: 7] = 7'h53;
        req = 4'b1100;
        wait_n = 0;
        while (gnt === 4'b0 && wait_n < 40) begin
            @(posedge clk); #1;
            wait_n++;
        end
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_err++; $display("FAIL timeout_grant: gnt=%b want 0100", gnt);
        end
        req[2] = 1'b0;
        wait_n = 0;
        while (rsp_valid === 4'b0 && wait_n < 5000) begin
            @(posedge clk); #1;
            wait_n++;
        end
        n_cmp++;
        if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || wait_n != 4122) begin
            n_err++; $display("FAIL timeout_resp: rsp_valid=%b err=%b rdata=%h cycles=%0d want 0100 1 00 4122",
                              rsp_valid, rsp_err, rsp_rdata, wait_n);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_err++; $display("FAIL timeout_next_grant: gnt=%b want 1000", gnt);
        end
        req[3] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        m_rdata = 8'h66; m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 4'b1000 || rsp_err !== 1'b0 || rsp_rdata !== 8'h66) begin
            n_err++; $display("FAIL timeout_recover: rsp_valid=%b err=%b rdata=%h want 1000 0 66",
                              rsp_valid, rsp_err, rsp_rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_stale_done();
        test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
